// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage MIPS core.
// Drives PC / IF/ID / ID/EX enables, flush and bubble controls for load-use
// stalls, branch/jr operand stalls (branches and jr resolve in ID),
// taken-branch/jump squash of the fetched slot, and external memory hold.
//
// Optional feature macro: HAZARD_STATS_EN (saturating stall/flush counters).
//
// Ports:
//   clk, reset (async, active-low)
//   id_rs, id_rt, id_uses_rs, id_uses_rt   : ID source operands
//   id_is_branch, id_is_jump, id_is_jr      : ID control class
//   branch_taken                            : ID comparator result
//   ex_reg_write, ex_mem_read, ex_dst       : instruction in EX
//   mem_mem_read, mem_dst                   : instruction in MEM
//   ext_hold                                : freeze whole pipeline
//   pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold : controls
//   stat_stall_cnt, stat_flush_cnt          : statistics (0 unless enabled)
//
// state | meaning
// RUN   | hazards evaluated every cycle; N=1 stalls stay in RUN
// STALL | extra stall cycles of a load->branch/jr hazard, counted by cnt
module hazard_ctrl #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_is_jump,
  input  logic              id_is_jr,
  input  logic              branch_taken,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_dst,
  input  logic              mem_mem_read,
  input  logic [4:0]        mem_dst,
  input  logic              ext_hold,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_hold,
  output logic [STAT_W-1:0] stat_stall_cnt,
  output logic [STAT_W-1:0] stat_flush_cnt
);

  typedef enum logic {S_RUN = 1'b0, S_STALL = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       dep_ex, dep_mem, resolves_in_id, redirect;
  logic [1:0] n_stall;

  // Register 0 is hard-wired, so it never creates a dependency.
  assign dep_ex  = (ex_dst != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_dst)) || (id_uses_rt && (id_rt == ex_dst)));
  assign dep_mem = (mem_dst != 5'd0) &&
                   ((id_uses_rs && (id_rs == mem_dst)) || (id_uses_rt && (id_rt == mem_dst)));

  assign resolves_in_id = id_is_branch || id_is_jr;
  assign redirect       = id_is_jump || id_is_jr || (id_is_branch && branch_taken);

  // Largest applicable stall length wins; the N=2 case is checked last.
  always_comb begin
    n_stall = 2'd0;
    if (ex_mem_read && dep_ex)                                      n_stall = 2'd1;
    if (resolves_in_id && ex_reg_write && !ex_mem_read && dep_ex)   n_stall = 2'd1;
    if (resolves_in_id && mem_mem_read && dep_mem)                  n_stall = 2'd1;
    if (resolves_in_id && ex_mem_read && dep_ex)                    n_stall = 2'd2;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (!reset) begin
      // outputs forced low while reset is asserted
    end else if (ext_hold) begin
      pipe_hold = 1'b1;
    end else if (state_q == S_STALL) begin
      id_ex_bubble = 1'b1;
      cnt_d        = cnt_q - 2'd1;
      if (cnt_d == 2'd0) state_d = S_RUN;
    end else if (n_stall != 2'd0) begin
      // A stall overrides any redirect; the branch re-resolves later.
      id_ex_bubble = 1'b1;
      if (n_stall == 2'd2) begin
        cnt_d   = 2'd1;
        state_d = S_STALL;
      end
    end else if (redirect) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

  // id_ex_bubble is high exactly on non-held stall cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_ex_bubble && (stall_cnt_q != {STAT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    if (if_id_flush  && (flush_cnt_q != {STAT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_flush_cnt = flush_cnt_q;
`else
  assign stat_stall_cnt = '0;
  assign stat_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam logic [4:0] O_ZERO  = 5'b00000;
  localparam logic [4:0] O_NORM  = 5'b11000;
  localparam logic [4:0] O_REDIR = 5'b11100;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_HOLD  = 5'b00001;
`ifdef HAZARD_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  logic       id_uses_rs, id_uses_rt, id_is_branch, id_is_jump, id_is_jr, branch_taken;
  logic       ex_reg_write, ex_mem_read, mem_mem_read, ext_hold;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;
  logic [3:0] stat_stall_cnt, stat_flush_cnt;
  logic [4:0] outs;
  logic [3:0] exp_s, exp_f;
  int         checks = 0;
  int         errors = 0;

  assign outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold};

  always #5 clk = ~clk;

  hazard_ctrl #(.STAT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_is_jump(id_is_jump), .id_is_jr(id_is_jr),
    .branch_taken(branch_taken),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .mem_mem_read(mem_mem_read), .mem_dst(mem_dst), .ext_hold(ext_hold),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold),
    .stat_stall_cnt(stat_stall_cnt), .stat_flush_cnt(stat_flush_cnt)
  );

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; ex_dst = 5'd0; mem_dst = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_branch = 1'b0; id_is_jump = 1'b0;
    id_is_jr = 1'b0; branch_taken = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_mem_read = 1'b0; ext_hold = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic set_ld_branch();
    clr();
    id_is_branch = 1'b1; branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd9;
    id_rt = 5'd9; id_uses_rt = 1'b1;
  endtask

  task automatic test_reset();
    clr();
    reset = 1'b0;
    ex_mem_read = 1'b1; ex_dst = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; ext_hold = 1'b1;
    #1;
    checks++; if (outs !== O_ZERO) begin errors++; $display("FAIL reset_outs got %b want %b", outs, O_ZERO); end
    checks++; if (stat_stall_cnt !== 4'd0 || stat_flush_cnt !== 4'd0) begin errors++;
      $display("FAIL reset_stats got %0d/%0d want 0/0", stat_stall_cnt, stat_flush_cnt); end
    tick();
    clr();
    reset = 1'b1;
    #1;
    checks++; if (outs !== O_NORM) begin errors++; $display("FAIL post_reset_norm got %b want %b", outs, O_NORM); end
    tick();
  endtask

  task automatic test_load_use();
    clr();
    ex_mem_read = 1'b1; ex_dst = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL load_use_stall got %b want %b", outs, O_STALL); end
    tick();
    ex_mem_read = 1'b0; mem_mem_read = 1'b1; mem_dst = 5'd8;
    #1;
    checks++; if (outs !== O_NORM) begin errors++; $display("FAIL load_use_release got %b want %b", outs, O_NORM); end
    tick();
    clr();
    ex_mem_read = 1'b1; ex_dst = 5'd8; id_rt = 5'd8; id_rs = 5'd3; id_uses_rs = 1'b1;
    #1;
    checks++; if (outs !== O_NORM) begin errors++; $display("FAIL uses_rt_gate got %b want %b", outs, O_NORM); end
    tick();
    id_uses_rt = 1'b1;
    #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL load_use_rt got %b want %b", outs, O_STALL); end
    tick();
    clr();
    ex_reg_write = 1'b1; ex_dst = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    #1;
    checks++; if (outs !== O_NORM) begin errors++; $display("FAIL alu_no_stall got %b want %b", outs, O_NORM); end
    tick();
  endtask

  task automatic test_load_branch();
    do_reset();
    set_ld_branch();
    #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL ldbr_stall1 got %b want %b", outs, O_STALL); end
    tick();
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = 5'd0;
    #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL ldbr_stall2 got %b want %b", outs, O_STALL); end
    tick();
    #1;
    checks++; if (outs !== O_REDIR) begin errors++; $display("FAIL ldbr_redirect got %b want %b", outs, O_REDIR); end
    tick();
    clr();
    #1;
    checks++; if (outs !== O_NORM) begin errors++; $display("FAIL ldbr_after got %b want %b", outs, O_NORM); end
    exp_s = STATS_ON ? 4'd2 : 4'd0;
    exp_f = STATS_ON ? 4'd1 : 4'd0;
    checks++; if (stat_stall_cnt !== exp_s || stat_flush_cnt !== exp_f) begin errors++;
      $display("FAIL ldbr_stats got %0d/%0d want %0d/%0d", stat_stall_cnt, stat_flush_cnt, exp_s, exp_f); end
    tick();
  endtask

  task automatic test_branch_deps();
    clr();
    id_is_branch = 1'b1; branch_taken = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd4;
    id_rs = 5'd4; id_uses_rs = 1'b1;
    #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL br_alu_stall got %b want %b", outs, O_STALL); end
    tick();
    ex_reg_write = 1'b0; ex_dst = 5'd0;
    #1;
    checks++; if (outs !== O_REDIR) begin errors++; $display("FAIL br_alu_redir got %b want %b", outs, O_REDIR); end
    tick();
    clr();
    id_is_branch = 1'b1; mem_mem_read = 1'b1; mem_dst = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
    #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL br_memld_stall got %b want %b", outs, O_STALL); end
    tick();
    mem_mem_read = 1'b0;
    #1;
    checks++; if (outs !== O_NORM) begin errors++; $display("FAIL br_not_taken got %b want %b", outs, O_NORM); end
    tick();
    clr();
    id_is_jr = 1'b1; id_rs = 5'd6; id_uses_rs = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd6;
    #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL jr_alu_stall got %b want %b", outs, O_STALL); end
    tick();
    ex_reg_write = 1'b0;
    #1;
    checks++; if (outs !== O_REDIR) begin errors++; $display("FAIL jr_redir got %b want %b", outs, O_REDIR); end
    tick();
    clr();
    mem_mem_read = 1'b1; mem_dst = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    #1;
    checks++; if (outs !== O_NORM) begin errors++; $display("FAIL memld_nobranch got %b want %b", outs, O_NORM); end
    tick();
  endtask

  task automatic test_zero();
    clr();
    ex_mem_read = 1'b1; ex_dst = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    #1;
    checks++; if (outs !== O_NORM) begin errors++; $display("FAIL zero_no_stall got %b want %b", outs, O_NORM); end
    id_is_jump = 1'b1;
    #1;
    checks++; if (outs !== O_REDIR) begin errors++; $display("FAIL jump_redir got %b want %b", outs, O_REDIR); end
    tick();
    clr();
  endtask

  task automatic test_hold_stall();
    do_reset();
    set_ld_branch();
    #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL hold_pre got %b want %b", outs, O_STALL); end
    tick();
    clr();
    ext_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (outs !== O_HOLD) begin errors++; $display("FAIL hold_in_stall[%0d] got %b want %b", i, outs, O_HOLD); end
      tick();
    end
    ext_hold = 1'b0; id_is_branch = 1'b1; branch_taken = 1'b1;
    #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL hold_remaining got %b want %b", outs, O_STALL); end
    tick();
    #1;
    checks++; if (outs !== O_REDIR) begin errors++; $display("FAIL hold_then_redir got %b want %b", outs, O_REDIR); end
    tick();
    clr();
    ext_hold = 1'b1; ex_mem_read = 1'b1; ex_dst = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    #1;
    checks++; if (outs !== O_HOLD) begin errors++; $display("FAIL hold_over_stall got %b want %b", outs, O_HOLD); end
    tick();
    exp_s = STATS_ON ? 4'd2 : 4'd0;
    exp_f = STATS_ON ? 4'd1 : 4'd0;
    checks++; if (stat_stall_cnt !== exp_s || stat_flush_cnt !== exp_f) begin errors++;
      $display("FAIL hold_stats got %0d/%0d want %0d/%0d", stat_stall_cnt, stat_flush_cnt, exp_s, exp_f); end
    clr();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_ld_branch();
    tick();
    clr();
    reset = 1'b0;
    #1;
    checks++; if (outs !== O_ZERO) begin errors++; $display("FAIL rst_mid_outs got %b want %b", outs, O_ZERO); end
    checks++; if (stat_stall_cnt !== 4'd0 || stat_flush_cnt !== 4'd0) begin errors++;
      $display("FAIL rst_mid_stats got %0d/%0d want 0/0", stat_stall_cnt, stat_flush_cnt); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (outs !== O_NORM) begin errors++; $display("FAIL rst_mid_run got %b want %b", outs, O_NORM); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    clr();
    ex_mem_read = 1'b1; ex_dst = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    repeat (20) tick();
    exp_s = STATS_ON ? 4'd15 : 4'd0;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL sat_outs got %b want %b", outs, O_STALL); end
    checks++; if (stat_stall_cnt !== exp_s) begin errors++;
      $display("FAIL sat_stall_cnt got %0d want %0d", stat_stall_cnt, exp_s); end
    clr();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    reset = 1'b0;
    tick();
    test_reset();
    test_load_use();
    test_load_branch();
    test_branch_deps();
    test_zero();
    test_hold_stall();
    test_reset_mid_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
